// File: rtl/memory_stage.sv
// Memory stage: runs loads/stores on a req/gnt/rvalid data bus and registers the
// writeback bundle. State | meaning: IDLE accept op | REQ request until gnt | RESP wait rvalid
module memory_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_alu_y_i,
    input  logic [XLEN-1:0] ex_rrd2_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_regwe_i,
    input  logic            ex_mem_re_i,
    input  logic            ex_mem_we_i,
    input  logic [1:0]      ex_mem_size_i,
    input  logic            ex_mem_unsigned_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_regwe_o,
    output logic [4:0]      wb_regwa_o,
    output logic [XLEN-1:0] wb_regwd_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            is_store_q, is_store_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            regwe_q, regwe_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_regwe_q, wb_regwe_d;
    logic [4:0]      wb_regwa_q, wb_regwa_d;
    logic [XLEN-1:0] wb_regwd_q, wb_regwd_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;

    logic            mem_op;
    logic            misaligned;
    logic [1:0]      ex_off;
    logic            tmo;
    logic [7:0]      lane8;
    logic [15:0]     lane16;
    logic [XLEN-1:0] load_data;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new;

    assign mem_op = ex_mem_re_i | ex_mem_we_i;
    assign ex_off = ex_alu_y_i[1:0];
    assign tmo    = (cnt_q == TMO_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = ex_rrd2_i;
        case (ex_mem_size_i)
            2'b00: begin
                be_new    = 4'b0001 << ex_off;
                wdata_new = {(XLEN/8){ex_rrd2_i[7:0]}};
            end
            2'b01: begin
                misaligned = ex_off[0];
                be_new     = 4'b0011 << ex_off;
                wdata_new  = {(XLEN/16){ex_rrd2_i[15:0]}};
            end
            2'b10:   misaligned = (ex_off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane extraction uses the offset captured at accept, not the live EX address.
    assign lane8  = dmem_rdata_i[{off_q, 3'b000} +: 8];
    assign lane16 = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {{(XLEN-8){1'b0}}, lane8}
                                       : {{(XLEN-8){lane8[7]}}, lane8};
            2'b01:   load_data = uns_q ? {{(XLEN-16){1'b0}}, lane16}
                                       : {{(XLEN-16){lane16[15]}}, lane16};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        regwe_d    = regwe_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wb_valid_d = 1'b0;
        wb_regwe_d = 1'b0;
        wb_regwa_d = wb_regwa_q;
        wb_regwd_d = wb_regwd_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ex_valid_i) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_regwe_d = ex_regwe_i;
                        wb_regwa_d = ex_rd_i;
                        wb_regwd_d = ex_alu_y_i;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_regwa_d = ex_rd_i;
                        misalign_d = 1'b1;
                    end else begin
                        is_store_d = ex_mem_we_i;
                        addr_d     = {ex_alu_y_i[XLEN-1:2], 2'b00};
                        be_d       = be_new;
                        wdata_d    = wdata_new;
                        rd_d       = ex_rd_i;
                        regwe_d    = ex_regwe_i;
                        size_d     = ex_mem_size_i;
                        uns_d      = ex_mem_unsigned_i;
                        off_d      = ex_off;
                        state_d    = REQ;
                        stall_o    = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (dmem_gnt_i && is_store_q) begin
                    wb_valid_d = 1'b1;
                    wb_regwa_d = rd_q;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else if (tmo) begin
                    wb_valid_d = 1'b1;
                    wb_regwa_d = rd_q;
                    bus_err_d  = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else begin
                    stall_o = 1'b1;
                    if (dmem_gnt_i) state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_regwe_d = regwe_q && (rd_q != 5'd0);
                    wb_regwa_d = rd_q;
                    wb_regwd_d = load_data;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else if (tmo) begin
                    wb_valid_d = 1'b1;
                    wb_regwa_d = rd_q;
                    bus_err_d  = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwe_q    <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_regwe_q <= 1'b0;
            wb_regwa_q <= '0;
            wb_regwd_q <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            regwe_q    <= regwe_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            wb_valid_q <= wb_valid_d;
            wb_regwe_q <= wb_regwe_d;
            wb_regwa_q <= wb_regwa_d;
            wb_regwd_q <= wb_regwd_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dmem_we_o    = dmem_req_o & is_store_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

    assign wb_valid_o = wb_valid_q;
    assign wb_regwe_o = wb_regwe_q;
    assign wb_regwa_o = wb_regwa_q;
    assign wb_regwd_o = wb_regwd_q;
    assign misalign_o = misalign_q;
    assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change 1ns after posedge, outputs
// are checked at negedge.
module tb_memory_stage;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_alu_y_i;
    logic [XLEN-1:0] ex_rrd2_i;
    logic [4:0]      ex_rd_i;
    logic            ex_regwe_i;
    logic            ex_mem_re_i;
    logic            ex_mem_we_i;
    logic [1:0]      ex_mem_size_i;
    logic            ex_mem_unsigned_i;
    logic            stall_o;
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;
    logic            wb_valid_o;
    logic            wb_regwe_o;
    logic [4:0]      wb_regwa_o;
    logic [XLEN-1:0] wb_regwd_o;
    logic            misalign_o;
    logic            bus_err_o;

    int errors = 0;
    int checks = 0;

    memory_stage #(.XLEN(XLEN), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ex_valid_i(ex_valid_i), .ex_alu_y_i(ex_alu_y_i), .ex_rrd2_i(ex_rrd2_i),
        .ex_rd_i(ex_rd_i), .ex_regwe_i(ex_regwe_i), .ex_mem_re_i(ex_mem_re_i),
        .ex_mem_we_i(ex_mem_we_i), .ex_mem_size_i(ex_mem_size_i),
        .ex_mem_unsigned_i(ex_mem_unsigned_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_regwe_o(wb_regwe_o), .wb_regwa_o(wb_regwa_o),
        .wb_regwd_o(wb_regwd_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task clear_ex();
        ex_valid_i        = 1'b0;
        ex_alu_y_i        = '0;
        ex_rrd2_i         = '0;
        ex_rd_i           = '0;
        ex_regwe_i        = 1'b0;
        ex_mem_re_i       = 1'b0;
        ex_mem_we_i       = 1'b0;
        ex_mem_size_i     = 2'b00;
        ex_mem_unsigned_i = 1'b0;
    endtask

    task test_reset();
        reset_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({stall_o, dmem_req_o, dmem_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: stall/req/we=%b expected 000", {stall_o, dmem_req_o, dmem_we_o});
        end
        checks++;
        if ({wb_valid_o, wb_regwe_o, misalign_o, bus_err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_wb: valid/we/mis/err=%b expected 0000",
                     {wb_valid_o, wb_regwe_o, misalign_o, bus_err_o});
        end
        checks++;
        if (wb_regwd_o !== 32'h0 || wb_regwa_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_wbdata: wd=%h wa=%0d expected 0/0", wb_regwd_o, wb_regwa_o);
        end
        next_cycle();
    endtask

    task test_alu_op();
        ex_valid_i = 1'b1; ex_alu_y_i = 32'h0000_1234; ex_rd_i = 5'd5; ex_regwe_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: stall=%b req=%b expected 0/0", stall_o, dmem_req_o);
        end
        next_cycle();
        clear_ex();
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b1 || wb_regwa_o !== 5'd5 || wb_regwd_o !== 32'h1234) begin
            errors++;
            $display("FAIL alu_wb: valid=%b we=%b wa=%0d wd=%h expected 1/1/5/00001234",
                     wb_valid_o, wb_regwe_o, wb_regwa_o, wb_regwd_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_wb_drop: wb_valid=%b expected 0", wb_valid_o);
        end
    endtask

    task test_store_byte();
        next_cycle();
        ex_valid_i = 1'b1; ex_mem_we_i = 1'b1; ex_mem_size_i = 2'b00;
        ex_alu_y_i = 32'h0000_0103; ex_rrd2_i = 32'h0000_00AB; ex_rd_i = 5'd9;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_accept: stall=%b req=%b expected 1/0", stall_o, dmem_req_o);
        end
        next_cycle();
        ex_alu_y_i = 32'hFFFF_FFFF; ex_rrd2_i = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            dmem_gnt_i = (i == 2);
            @(negedge clk_i);
            checks++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h100 ||
                dmem_be_o !== 4'b1000 || dmem_wdata_o !== 32'hABAB_ABAB) begin
                errors++;
                $display("FAIL sb_bus[%0d]: req=%b we=%b addr=%h be=%b wd=%h expected 1/1/100/1000/ababab",
                         i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
            end
            checks++;
            if (stall_o !== (i != 2)) begin
                errors++;
                $display("FAIL sb_stall[%0d]: stall=%b expected %b", i, stall_o, (i != 2));
            end
            next_cycle();
        end
        dmem_gnt_i = 1'b0;
        clear_ex();
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_wb: valid=%b we=%b req=%b expected 1/0/0", wb_valid_o, wb_regwe_o, dmem_req_o);
        end
        next_cycle();
    endtask

    task test_load_half(input logic uns, input logic [31:0] exp_wd);
        ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b01; ex_mem_unsigned_i = uns;
        ex_alu_y_i = 32'h0000_0202; ex_rd_i = 5'd7; ex_regwe_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL lh_accept: stall=%b expected 1", stall_o);
        end
        next_cycle();
        clear_ex();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h200 ||
            dmem_be_o !== 4'b1100 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL lh_req: req=%b we=%b addr=%h be=%b stall=%b expected 1/0/200/1100/1",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, stall_o);
        end
        next_cycle();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
        @(negedge clk_i);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL lh_resp: req=%b stall=%b expected 0/0", dmem_req_o, stall_o);
        end
        next_cycle();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b1 || wb_regwa_o !== 5'd7 || wb_regwd_o !== exp_wd) begin
            errors++;
            $display("FAIL lh_wb(u=%b): valid=%b we=%b wa=%0d wd=%h expected 1/1/7/%h",
                     uns, wb_valid_o, wb_regwe_o, wb_regwa_o, wb_regwd_o, exp_wd);
        end
        next_cycle();
    endtask

    task test_load_byte_rd0();
        ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b00;
        ex_alu_y_i = 32'h0000_0101; ex_rd_i = 5'd0; ex_regwe_i = 1'b1;
        next_cycle();
        clear_ex();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (dmem_be_o !== 4'b0010) begin
            errors++;
            $display("FAIL lb_be: be=%b expected 0010", dmem_be_o);
        end
        next_cycle();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_F500;
        next_cycle();
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b0 || wb_regwd_o !== 32'hFFFF_FFF5) begin
            errors++;
            $display("FAIL lb_rd0: valid=%b we=%b wd=%h expected 1/0/fffffff5", wb_valid_o, wb_regwe_o, wb_regwd_o);
        end
        next_cycle();
    endtask

    task test_misalign();
        ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b10;
        ex_alu_y_i = 32'h0000_0301; ex_rd_i = 5'd4; ex_regwe_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_accept: stall=%b req=%b expected 0/0", stall_o, dmem_req_o);
        end
        next_cycle();
        clear_ex();
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || misalign_o !== 1'b1 || wb_regwe_o !== 1'b0 ||
            dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_wb: valid=%b mis=%b we=%b req=%b stall=%b expected 1/1/0/0/0",
                     wb_valid_o, misalign_o, wb_regwe_o, dmem_req_o, stall_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (misalign_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: mis=%b valid=%b expected 0/0", misalign_o, wb_valid_o);
        end
    endtask

    task test_timeout();
        int n;
        logic last_stall;
        n = 0;
        last_stall = 1'b1;
        ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b10;
        ex_alu_y_i = 32'h0000_0400; ex_rd_i = 5'd3; ex_regwe_i = 1'b1;
        next_cycle();
        clear_ex();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (dmem_req_o !== 1'b1) break;
            n++;
            last_stall = stall_o;
            next_cycle();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL tmo_len: req cycles=%0d expected 8", n);
        end
        checks++;
        if (last_stall !== 1'b0) begin
            errors++;
            $display("FAIL tmo_stall: stall in last req cycle=%b expected 0", last_stall);
        end
        checks++;
        if (bus_err_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wb: err=%b valid=%b we=%b expected 1/1/0", bus_err_o, wb_valid_o, wb_regwe_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: err=%b expected 0", bus_err_o);
        end
    endtask

    task test_back_to_back();
        ex_valid_i = 1'b1; ex_mem_we_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b01;
        ex_alu_y_i = 32'h0000_0002; ex_rrd2_i = 32'h1234_BEEF;
        next_cycle();
        clear_ex();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (dmem_we_o !== 1'b1 || dmem_be_o !== 4'b1100 || dmem_wdata_o !== 32'hBEEF_BEEF || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL sh_bus: we=%b be=%b wd=%h stall=%b expected 1/1100/beefbeef/0",
                     dmem_we_o, dmem_be_o, dmem_wdata_o, stall_o);
        end
        next_cycle();
        dmem_gnt_i = 1'b0;
        ex_valid_i = 1'b1; ex_alu_y_i = 32'hCAFE_0001; ex_rd_i = 5'd12; ex_regwe_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwe_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store_wb: valid=%b we=%b stall=%b expected 1/0/0", wb_valid_o, wb_regwe_o, stall_o);
        end
        next_cycle();
        clear_ex();
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_regwd_o !== 32'hCAFE_0001 || wb_regwa_o !== 5'd12) begin
            errors++;
            $display("FAIL b2b_alu_wb: valid=%b wd=%h wa=%0d expected 1/cafe0001/12", wb_valid_o, wb_regwd_o, wb_regwa_o);
        end
        next_cycle();
    endtask

    task test_reset_mid_resp();
        ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_size_i = 2'b10;
        ex_alu_y_i = 32'h0000_0500; ex_rd_i = 5'd4; ex_regwe_i = 1'b1;
        next_cycle();
        clear_ex();
        dmem_gnt_i = 1'b1;
        next_cycle();
        dmem_gnt_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp: stall=%b req=%b expected 1/0", stall_o, dmem_req_o);
        end
        next_cycle();
        reset_i = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: stall=%b req=%b valid=%b expected 0/0/0", stall_o, dmem_req_o, wb_valid_o);
        end
        next_cycle();
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (wb_valid_o !== 1'b0 || wb_regwe_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_rvalid: valid=%b we=%b expected 0/0", wb_valid_o, wb_regwe_o);
        end
        next_cycle();
    endtask

    initial begin
        reset_i = 1'b0;
        clear_ex();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_alu_op();
        test_store_byte();
        test_load_half(1'b0, 32'hFFFF_8001);
        test_load_half(1'b1, 32'h0000_8001);
        test_load_byte_rd0();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
